// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential accumulator ALU with a valid/ready command port,
// a registered valid/ready result port and an iterative restoring divider.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable while valid && !ready. A raised
// valid is never withdrawn before its transfer. in_ready is high only in IDLE,
// so at most one command is in flight.
module alu_seq_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             dz,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_DIVIDE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_HOLD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_REM  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_XNOR = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_SHR  = 4'd14;
  localparam logic [3:0] OP_CLR  = 4'd15;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;         // captured operand A (divisor for DIV/REM)
  logic [WIDTH-1:0] b_q, b_d;         // captured Bop (b or accumulator)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // shifts dividend out, quotient in
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_dz;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [WIDTH-1:0] div_res;

  // Single-cycle datapath on the captured operands
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, b_q} - {1'b0, a_q};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_dz  = 1'b0;
    case (op_q)
      OP_HOLD: alu_res = acc_q;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (b_q[WIDTH-1] != a_q[WIDTH-1]) && (diff[WIDTH-1] != b_q[WIDTH-1]);
      end
      OP_MUL:  alu_res = a_q * b_q;
      // DIV/REM only reach the single-cycle path when the divisor is zero
      OP_DIV: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REM: begin
        alu_res = b_q;
        alu_dz  = 1'b1;
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~b_q;
      OP_NAND: alu_res = ~(a_q & b_q);
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      OP_SHL: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = '0;  // CLR
    endcase
  end

  // One restoring-division step: shift in next dividend bit, try subtract
  always_comb begin
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, a_q};
    div_res   = (op_q == OP_DIV) ? quo_q : rem_q;
  end

  // Next-state and output-register logic for the command FSM
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    dz_d        = dz_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          a_d  = a;
          b_d  = use_acc ? acc_q : b;
          if ((op == OP_DIV || op == OP_REM) && a != '0) begin
            cnt_d   = CNT_INIT;
            rem_d   = '0;
            quo_d   = use_acc ? acc_q : b;
            state_d = S_DIVIDE;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d    = alu_res;
        carry_d     = alu_c;
        ovf_d       = alu_v;
        zero_d      = (alu_res == '0);
        dz_d        = alu_dz;
        acc_d       = alu_res;
        // CLR wins over any flag that would otherwise set err
        err_d       = (op_q == OP_CLR) ? 1'b0
                    : (err_q | ((op_q == OP_ADD) && alu_c) | alu_v | alu_dz);
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_DIVIDE: begin
        if (cnt_q != '0) begin
          if (div_trial[WIDTH]) begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = div_trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d    = div_res;
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          zero_d      = (div_res == '0);
          dz_d        = 1'b0;
          acc_d       = div_res;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      default: begin  // S_OUT
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign dz        = dz_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Testbench for alu_seq_core: directed and random commands, expected results
// from a behavioural model pushed into a queue and checked on out_valid.
module tb_alu_seq_core;
  localparam int W  = 32;
  localparam int EW = W + 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, ovf, zero, dz, err;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];   // {result, carry, ovf, zero, dz, err}
  int            lat_q[$];
  logic [W-1:0]  m_acc;
  logic          m_err;

  // Clock
  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .ovf(ovf),
    .zero(zero), .dz(dz), .err(err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver: compute expectation with the model, then present one command
  task automatic send(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ua);
    logic [W-1:0] bop, r;
    logic [W:0]   wide;
    logic         c, v, z, d;
    longint       s, smax, smin;
    int           t;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_before_cmd", in_ready, 1);
    bop = ua ? m_acc : bv;
    c = 0; v = 0; d = 0; r = '0;
    case (o)
      4'd0: r = m_acc;
      4'd1: begin
        wide = {1'b0, av} + {1'b0, bop};
        r = wide[W-1:0]; c = wide[W];
        s = longint'($signed(av)) + longint'($signed(bop));
        v = (s > smax) || (s < smin);
      end
      4'd2: begin
        r = bop - av; c = (av > bop);
        s = longint'($signed(bop)) - longint'($signed(av));
        v = (s > smax) || (s < smin);
      end
      4'd3: r = av * bop;
      4'd4: if (av == 0) begin r = '1; d = 1; end else r = bop / av;
      4'd5: if (av == 0) begin r = bop; d = 1; end else r = bop % av;
      4'd6: r = av & bop;
      4'd7: r = av | bop;
      4'd8: r = av ^ bop;
      4'd9: r = ~bop;
      4'd10: r = ~(av & bop);
      4'd11: r = ~(av | bop);
      4'd12: r = ~(av ^ bop);
      4'd13: begin r = av << 1; c = av[W-1]; end
      4'd14: begin r = av >> 1; c = av[0]; end
      default: r = '0;
    endcase
    z = (r == 0);
    m_err = (o == 4'd15) ? 1'b0 : (m_err | ((o == 4'd1) && c) | v | d);
    m_acc = r;
    exp_q.push_back({r, c, v, z, d, m_err});
    lat_q.push_back(((o == 4'd4 || o == 4'd5) && av != 0) ? W + 1 : 1);
    op = o; a = av; b = bv; use_acc = ua; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // scramble inputs: captured operands must not follow them
    op = 4'($urandom_range(15, 0)); a = $urandom; b = $urandom;
    use_acc = 1'($urandom_range(1, 0));
  endtask

  // Monitor/scoreboard: wait for result, compare, hold, then handshake
  task automatic collect(input int hold);
    int            cyc;
    logic          seen_ready;
    logic [EW-1:0] e, snap;
    int            lat;
    cyc = 0; seen_ready = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (!out_valid && in_ready) seen_ready = 1;
    end
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    lat = lat_q.pop_front();
    check("latency", cyc, lat);
    check("in_ready_busy", seen_ready, 0);
    check("in_ready_out", in_ready, 0);
    check("result", result, e[EW-1:5]);
    check("carry", carry, e[4]);
    check("ovf", ovf, e[3]);
    check("zero", zero, e[2]);
    check("dz", dz, e[1]);
    check("err", err, e[0]);
    snap = {result, carry, ovf, zero, dz, err};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'd1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_stable", {result, carry, ovf, zero, dz, err}, snap);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    use_acc = 1'b0; m_acc = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, ovf, zero, dz, err}, 0);
    check("rst_state", dbg_state, 0);

    // carry, err, then CLR
    send(4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0); collect(0);
    send(4'd15, 32'd0, 32'd0, 1'b0);        collect(0);
    // borrow and signed overflow
    send(4'd2, 32'd5, 32'd3, 1'b0);         collect(0);
    send(4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0); collect(0);
    // divider and divide by zero
    send(4'd4, 32'd7, 32'd100, 1'b0);       collect(0);
    send(4'd5, 32'd7, 32'd100, 1'b0);       collect(0);
    send(4'd4, 32'd0, 32'd9, 1'b0);         collect(0);
    send(4'd5, 32'd0, 32'd9, 1'b0);         collect(0);
    // accumulate chain
    send(4'd15, 32'd0, 32'd0, 1'b0);        collect(0);
    send(4'd1, 32'd3, 32'd4, 1'b0);         collect(0);
    send(4'd1, 32'd10, 32'd0, 1'b1);        collect(0);
    send(4'd3, 32'd2, 32'd0, 1'b1);         collect(0);
    send(4'd0, 32'd0, 32'd0, 1'b1);         collect(0);
    // backpressure, then a normal command
    send(4'd1, 32'd20, 32'd22, 1'b0);       collect(5);
    send(4'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0); collect(0);
    // shift edges
    send(4'd13, 32'h8000_0001, 32'd0, 1'b0); collect(0);
    send(4'd14, 32'h8000_0003, 32'd0, 1'b0); collect(0);
    send(4'd14, 32'd0, 32'd0, 1'b0);         collect(0);
    // every op once with random operands
    for (int o = 0; o < 16; o++) begin
      send(4'(o), $urandom, $urandom, 1'b0); collect(0);
    end
    // random mix with random backpressure
    repeat (40) begin
      ro = 4'($urandom_range(15, 0));
      ra = ($urandom_range(7, 0) == 0) ? '0 : ((ro == 4'd4 || ro == 4'd5) ? W'($urandom_range(300, 1)) : $urandom);
      send(ro, ra, $urandom, 1'($urandom_range(1, 0)));
      collect($urandom_range(2, 0));
    end

    // reset in the middle of a divide
    send(4'd4, 32'd7, 32'd100, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_err", err, 0);
    m_acc = '0; m_err = 1'b0;
    exp_q.delete(); lat_q.delete();
    send(4'd0, 32'd0, 32'd0, 1'b0); collect(0);
    send(4'd1, 32'd1, 32'd1, 1'b0); collect(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
